// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweeper.
package sweep_pkg;

    localparam int unsigned SETTLE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    function automatic int unsigned num_vectors(input int unsigned n_width);
        return 32'd1 << n_width;
    endfunction

endpackage

// File: rtl/exhaustive_vector_sweeper_if.sv
// Response stream from the sweeper to the downstream logger.
interface exhaustive_vector_sweeper_if #(
    parameter int unsigned N_WIDTH   = 5,
    parameter int unsigned OUT_WIDTH = 1
) ();

    logic                 resp_valid;
    logic                 resp_ready;
    logic [N_WIDTH-1:0]   resp_vec;
    logic [OUT_WIDTH-1:0] resp_data;

    modport master (
        output resp_valid,
        output resp_vec,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_vec,
        input  resp_data,
        output resp_ready
    );

endinterface

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that paces the settle interval of each vector.
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero_c
);

    logic [SETTLE_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/exhaustive_vector_sweeper.sv
// Drives every input vector of the DUT in order, captures its truth table,
// compares against golden and streams each (vector, response) pair out.
module exhaustive_vector_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned N_WIDTH       = 5,
    parameter int unsigned OUT_WIDTH     = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                                      CK,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      abort,
    output logic [N_WIDTH-1:0]                        N,
    input  logic [OUT_WIDTH-1:0]                      dut_out,
    input  logic [num_vectors(N_WIDTH)*OUT_WIDTH-1:0] golden,
    exhaustive_vector_sweeper_if.master               resp,
    output logic                                      busy,
    output logic                                      done,
    output logic [num_vectors(N_WIDTH)*OUT_WIDTH-1:0] truth_table,
    output logic [N_WIDTH:0]                          mismatch_cnt,
    output logic [N_WIDTH-1:0]                        first_mismatch
);

    localparam int unsigned NV    = num_vectors(N_WIDTH);
    localparam int unsigned IDX_W = N_WIDTH + 1;
    localparam int unsigned TT_W  = NV * OUT_WIDTH;
    localparam int unsigned TT_AW = $clog2(TT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NV - 1);

    sweep_state_t         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_WIDTH-1:0]   idx_lo;
    logic [TT_AW-1:0]     tt_base;
    logic [OUT_WIDTH-1:0] golden_entry;

    logic                 valid_q, valid_d;
    logic [N_WIDTH-1:0]   vec_q, vec_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [N_WIDTH-1:0]   n_d;
    logic                 busy_d, done_d;
    logic [TT_W-1:0]      tt_d;
    logic [N_WIDTH:0]     mcnt_d;
    logic [N_WIDTH-1:0]   first_d;

    logic                 timer_load, timer_dec, timer_zero;
    logic                 handshake;

    sweep_settle_timer u_timer (
        .clk      (CK),
        .rst_n    (reset),
        .load     (timer_load),
        .load_val (SETTLE_W'(SETTLE_CYCLES)),
        .dec      (timer_dec),
        .zero_c   (timer_zero)
    );

    assign idx_lo       = idx_q[N_WIDTH-1:0];
    assign tt_base      = TT_AW'(idx_lo * OUT_WIDTH);
    assign golden_entry = golden[tt_base +: OUT_WIDTH];
    assign handshake    = valid_q & resp.resp_ready;

    assign resp.resp_valid = valid_q;
    assign resp.resp_vec   = vec_q;
    assign resp.resp_data  = data_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort overrides every transition, including a coincident start.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (start)      state_d = SETTLE;
                SETTLE:     if (timer_zero) state_d = EMIT;
                EMIT: begin
                    if (handshake) state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        idx_d      = idx_q;
        n_d        = N;
        valid_d    = valid_q;
        vec_d      = vec_q;
        data_d     = data_q;
        done_d     = done;
        tt_d       = truth_table;
        mcnt_d     = mismatch_cnt;
        first_d    = first_mismatch;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        if (abort) begin
            idx_d   = '0;
            n_d     = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_d      = '0;
                        n_d        = '0;
                        done_d     = 1'b0;
                        tt_d       = '0;
                        mcnt_d     = '0;
                        first_d    = '0;
                        timer_load = 1'b1;
                    end
                end
                SETTLE: begin
                    if (!timer_zero) begin
                        timer_dec = 1'b1;
                    end else begin
                        valid_d                    = 1'b1;
                        vec_d                      = idx_lo;
                        data_d                     = dut_out;
                        tt_d[tt_base +: OUT_WIDTH] = dut_out;
                        if (dut_out != golden_entry) begin
                            mcnt_d = mismatch_cnt + 1'b1;
                            if (mismatch_cnt == '0) first_d = idx_lo;
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_d = 1'b1;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            n_d        = N_WIDTH'(idx_q + 1'b1);
                            timer_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == SETTLE) || (state_d == EMIT);
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            idx_q          <= '0;
            N              <= '0;
            valid_q        <= 1'b0;
            vec_q          <= '0;
            data_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            truth_table    <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
        end else begin
            idx_q          <= idx_d;
            N              <= n_d;
            valid_q        <= valid_d;
            vec_q          <= vec_d;
            data_q         <= data_d;
            busy           <= busy_d;
            done           <= done_d;
            truth_table    <= tt_d;
            mismatch_cnt   <= mcnt_d;
            first_mismatch <= first_d;
        end
    end

endmodule
